fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the write port of one 16-entry x 16-bit synchronous FIFO between N_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST words.
- Tracks FIFO occupancy itself with a credit counter, so it never writes into a full FIFO and does not depend on a lagging full flag.
- Sits between the producer blocks and the FIFO's we/din inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 16, data width.
- DEPTH, 16, FIFO capacity in words.
- MAX_BURST, 4, maximum words per grant (1..DEPTH).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*DW  per-requester word; requester i occupies bits [i*DW +: DW].
- req_last  in  N_REQ  marks the final word of a requester's burst.
- req_ready  out  N_REQ  per-requester accept; combinational, one-hot or zero.
- fifo_we  out  1  registered FIFO write strobe.
- fifo_din  out  DW  registered FIFO write data.
- fifo_rd  in  1  pulse: the FIFO consumer popped one word this cycle.
- gnt_valid  out  1  a grant is active (state BURST).
- gnt_id  out  3  index of the granted requester; valid when gnt_valid = 1.
- level  out  5  credit counter, i.e. words currently held in the FIFO (0..DEPTH).

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; rr_ptr = 0; beat = 0; level = 0.
  - fifo_we = 0; fifo_din = 0; gnt_valid = 0; gnt_id = 0; req_ready = 0.
  - Reset mid-burst aborts the burst; a word accepted in the same cycle as reset is dropped.
- State IDLE:
  - req_ready = 0.
  - If any req_valid = 1, pick the first requester with valid set, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Register gnt_id, set beat = 0, go to BURST. This arbitration cycle costs one clock.
- State BURST (granted requester g):
  - req_ready[g] = req_valid[g] & (level < DEPTH). All other ready bits = 0.
  - A transfer occurs when req_valid[g] & req_ready[g]. On the next edge: fifo_we = 1, fifo_din = req_data[g], beat = beat + 1.
  - No transfer in a cycle: fifo_we = 0 on the next edge; fifo_din holds its last value.
  - Exit to IDLE with rr_ptr = (g+1) mod N_REQ when any of these is true:
    - a transfer occurs with req_last[g] = 1;
    - a transfer makes beat reach MAX_BURST;
    - req_valid[g] = 0 (requester withdrew; no penalty, no word written).
  - level = DEPTH with req_valid[g] = 1: stall in BURST with ready = 0. The grant is held, not released.
- Write latency: a word accepted in cycle t appears on fifo_we/fifo_din in cycle t+1.
- Credit counter (level):
  - Increment on a transfer; decrement on fifo_rd.
  - Both in the same cycle: level is unchanged.
  - fifo_rd with level = 0 is ignored (saturates at 0).
  - level never exceeds DEPTH.
- Fairness: after a grant ends, the requester just served has the lowest priority. A continuously requesting producer waits at most N_REQ-1 bursts.
- Requesters not granted must hold req_valid and req_data stable. The arbiter never drops an unaccepted word.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds input stat_clr (1 bit) and output stat_cnt (N_REQ*16 bits).
  - stat_cnt holds one 16-bit saturating count of accepted words per requester; requester i occupies [i*16 +: 16].
  - stat_clr = 1 zeroes all counters synchronously; clear takes priority over an increment in the same cycle.
  - rst = 0 resets all counters to 0.
- Undefined: the ports and the counters are absent; all other behaviour is identical.

Test Plan:
- Requester 0 alone sends 3 words 0x0001, 0x0002, 0x0003 with last on the third -> 1 arbitration cycle, then ready each cycle; fifo_we high for 3 consecutive cycles, each delayed one cycle from acceptance; level = 3; back to IDLE with rr_ptr = 1.
- All 4 requesters valid continuously, MAX_BURST = 4, no last -> grants in order 0,1,2,3,0; each grant writes exactly 4 words; 1 idle cycle between grants.
- Fill: requester 2 streams 20 words, no fifo_rd -> exactly 16 writes; level = 16; ready stays low with grant held. Then one fifo_rd pulse -> one more word accepted; level back to 16.
- fifo_rd and a transfer in the same cycle at level = 5 -> level stays 5. fifo_rd at level = 0 -> level stays 0.
- Requester 1 drops valid after 2 words, no last -> return to IDLE the next cycle; requester 2 granted next; no spurious write.
- Assert rst mid-burst at level = 7 -> asynchronous clear: fifo_we = 0, gnt_valid = 0, level = 0. With FIFO_ARB_STATS_EN defined, stat_cnt = 0 and stat_clr zeroes counters after traffic.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the FIFO write arbiter.
// The arbiter uses the slave modport. The producers and the FIFO model use the master modport.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16
) ();
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_ready;
  logic                fifo_we;
  logic [DW-1:0]       fifo_din;
  logic                fifo_rd;

  modport master (
    output req_valid, req_data, req_last, fifo_rd,
    input  req_ready, fifo_we, fifo_din
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_rd,
    output req_ready, fifo_we, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of one FIFO. It tracks FIFO occupancy with credits.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester accepted-word counters.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.slave     bus,
  output logic                 gnt_valid,
  output logic [2:0]           gnt_id,
  output logic [4:0]           level
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [N_REQ*16-1:0]  stat_cnt
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam int             BW       = $clog2(MAX_BURST + 1);
  localparam logic [4:0]     FULL     = 5'(DEPTH);
  localparam logic [BW-1:0]  BEAT_MAX = BW'(MAX_BURST);

  state_t          state, state_next;
  logic [2:0]      rr_ptr, rr_next;
  logic [2:0]      gnt_next;
  logic [BW-1:0]   beat, beat_next;

  logic            pick_found;
  logic [2:0]      pick_id;
  logic [3:0]      pick_sum;
  logic [2*N_REQ-1:0] valid_rot;

  logic [N_REQ-1:0] gnt_oh;
  logic            sel_valid, sel_last;
  logic [DW-1:0]   sel_data;

  logic            xfer, rd_eff;

  assign gnt_valid = (state == BURST);
  assign rd_eff    = bus.fifo_rd && (level != 5'd0);

  // Rotate the valid vector so bit 0 is rr_ptr. The lowest set bit wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_rot  = {bus.req_valid, bus.req_valid} >> rr_ptr;
    pick_found = 1'b0;
    pick_id    = '0;
    pick_sum   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        pick_sum = {1'b0, rr_ptr} + 4'(i);
        if (pick_sum >= 4'(N_REQ)) pick_sum = pick_sum - 4'(N_REQ);
        pick_found = 1'b1;
        pick_id    = pick_sum[2:0];
      end
    end
  end

  always_comb begin
    gnt_oh    = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == 3'(i)) begin
        gnt_oh[i] = 1'b1;
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_next    = state;
    rr_next       = rr_ptr;
    gnt_next      = gnt_id;
    beat_next     = beat;
    bus.req_ready = '0;
    xfer          = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = BURST;
          gnt_next   = pick_id;
          beat_next  = '0;
        end
      end
      BURST: begin
        if (!sel_valid) begin
          state_next = IDLE;
          rr_next    = (gnt_id == 3'(N_REQ - 1)) ? 3'd0 : gnt_id + 3'd1;
        end else if (level < FULL) begin
          bus.req_ready = gnt_oh;
          xfer          = 1'b1;
          beat_next     = beat + 1'b1;
          if (sel_last || (beat_next == BEAT_MAX)) begin
            state_next = IDLE;
            rr_next    = (gnt_id == 3'(N_REQ - 1)) ? 3'd0 : gnt_id + 3'd1;
          end
        end
        // A full FIFO keeps the grant and holds ready low until a credit returns.
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      beat   <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      gnt_id <= gnt_next;
      beat   <= beat_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.fifo_we  <= 1'b0;
      bus.fifo_din <= '0;
    end else begin
      bus.fifo_we <= xfer;
      if (xfer) bus.fifo_din <= sel_data;
    end
  end

  // A write and a read in the same cycle cancel. A read with no credit outstanding is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else begin
      case ({xfer, rd_eff})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this register array is small control state, not RAM, so it takes the async reset.
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else if (xfer) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((gnt_id == 3'(i)) && (stat_q[i] != 16'hFFFF)) stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_cnt[g*16 +: 16] = stat_q[g];
  end
`else
  // Statistics disabled: no counter state is built.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter. Accepted words are queued and matched against fifo_we/fifo_din.
// Define FIFO_ARB_STATS_EN for both the RTL and the bench to check the statistics counters as well.
module tb_fifo_wr_arbiter;
  localparam int N_REQ = 4, DW = 16, DEPTH = 16, MAX_BURST = 4;

  typedef struct packed { logic [DW-1:0] data; logic last; } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic [4:0] level;
`ifdef FIFO_ARB_STATS_EN
  logic                stat_clr = 1'b0;
  logic [N_REQ*16-1:0] stat_cnt;
`endif

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .level     (level)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  word_t         src_q [N_REQ][$];
  logic [DW-1:0] sb_q[$];
  int            gnt_log[$], burst_log[$], idle_log[$];
  int            n_checks = 0, n_errors = 0, n_writes = 0, lvl_model = 0;
  int            cur_burst = 0, idle_run = 0;
  int            acc_cnt [N_REQ];
  logic          prev_gnt = 1'b0;

  task automatic load(input int r, input int n, input logic [DW-1:0] base, input logic last_on_end);
    for (int k = 0; k < n; k++)
      src_q[r].push_back({base + DW'(k), (last_on_end && k == n - 1)});
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_data[i*DW +: DW]  = src_q[i][0].data;
        bus.req_last[i]           = src_q[i][0].last;
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_data[i*DW +: DW]  = '0;
        bus.req_last[i]           = 1'b0;
      end
    end
  endtask

  // One clock: capture acceptance before the edge, then check the registered outputs after the edge.
  task automatic step();
    logic [N_REQ-1:0] acc;
    logic [DW-1:0]    exp_data;
    logic             exp_we;
    logic             rd_eff;
    #1;
    acc = bus.req_valid & bus.req_ready;
    n_checks++;
    if (!$onehot0(bus.req_ready)) begin
      n_errors++;
      $display("FAIL ready_onehot: got %b, expected one-hot or zero", bus.req_ready);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i]) begin
        sb_q.push_back(src_q[i][0].data);
        acc_cnt[i]++;
      end
    end
    rd_eff = bus.fifo_rd && (lvl_model > 0);
    if ((acc != 0) && !rd_eff) lvl_model++;
    else if ((acc == 0) && rd_eff) lvl_model--;
    cur_burst += $countones(acc);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) if (acc[i]) void'(src_q[i].pop_front());
    exp_we = (sb_q.size() > 0);
    n_checks++;
    if (bus.fifo_we !== exp_we) begin
      n_errors++;
      $display("FAIL write_strobe: got %b, expected %b", bus.fifo_we, exp_we);
    end
    if (exp_we) begin
      exp_data = sb_q.pop_front();
      if (bus.fifo_we === 1'b1) begin
        n_checks++;
        if (bus.fifo_din !== exp_data) begin
          n_errors++;
          $display("FAIL write_data: got %h, expected %h", bus.fifo_din, exp_data);
        end
      end
    end
    if (bus.fifo_we === 1'b1) n_writes++;
    n_checks++;
    if (level !== 5'(lvl_model)) begin
      n_errors++;
      $display("FAIL level: got %0d, expected %0d", level, lvl_model);
    end
    if (gnt_valid && !prev_gnt) begin
      gnt_log.push_back(int'(gnt_id));
      idle_log.push_back(idle_run);
      idle_run = 0;
    end
    if (!gnt_valid && prev_gnt) begin
      burst_log.push_back(cur_burst);
      cur_burst = 0;
    end
    if (!gnt_valid) idle_run++;
    prev_gnt = gnt_valid;
    drive();
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_REQ; i++) begin
      src_q[i].delete();
      acc_cnt[i] = 0;
    end
    sb_q.delete();
    gnt_log.delete();
    burst_log.delete();
    idle_log.delete();
    lvl_model   = 0;
    cur_burst   = 0;
    idle_run    = 0;
    prev_gnt    = 1'b0;
    bus.fifo_rd = 1'b0;
    drive();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    bus.req_data  = '1;
    bus.req_last  = '0;
    bus.fifo_rd   = 1'b0;
    #2 rst = 1'b0;
    #2;
    n_checks++; if (bus.fifo_we !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b, expected 0", bus.fifo_we); end
    n_checks++; if (bus.fifo_din !== '0) begin n_errors++; $display("FAIL rst_din: got %h, expected 0", bus.fifo_din); end
    n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL rst_gnt_valid: got %b, expected 0", gnt_valid); end
    n_checks++; if (gnt_id !== 3'd0) begin n_errors++; $display("FAIL rst_gnt_id: got %0d, expected 0", gnt_id); end
    n_checks++; if (level !== 5'd0) begin n_errors++; $display("FAIL rst_level: got %0d, expected 0", level); end
    n_checks++; if (bus.req_ready !== '0) begin n_errors++; $display("FAIL rst_ready: got %b, expected 0", bus.req_ready); end
`ifdef FIFO_ARB_STATS_EN
    n_checks++; if (stat_cnt !== '0) begin n_errors++; $display("FAIL rst_stat: got %h, expected 0", stat_cnt); end
`endif
    clear_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    int w0 = n_writes;
    load(0, 3, 16'h0001, 1'b1);
    drive();
    #1;
    n_checks++; if (bus.req_ready !== '0) begin n_errors++; $display("FAIL single_arb_ready: got %b, expected 0", bus.req_ready); end
    step();
    n_checks++; if (gnt_valid !== 1'b1 || gnt_id !== 3'd0) begin n_errors++; $display("FAIL single_grant: got %b/%0d, expected 1/0", gnt_valid, gnt_id); end
    repeat (3) step();
    n_checks++; if (n_writes - w0 != 3) begin n_errors++; $display("FAIL single_writes: got %0d, expected 3", n_writes - w0); end
    n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL single_release: got %b, expected 0", gnt_valid); end
    n_checks++; if (level !== 5'd3) begin n_errors++; $display("FAIL single_level: got %0d, expected 3", level); end
    step();
  endtask

  // Pointer is 1 after the last test: with 0 and 2 requesting, 2 must win first.
  task automatic test_rr_ptr();
    load(0, 1, 16'h00A0, 1'b1);
    load(2, 1, 16'h02A0, 1'b1);
    drive();
    step();
    n_checks++; if (gnt_id !== 3'd2) begin n_errors++; $display("FAIL rr_first: got %0d, expected 2", gnt_id); end
    step();
    step();
    n_checks++; if (gnt_id !== 3'd0) begin n_errors++; $display("FAIL rr_second: got %0d, expected 0", gnt_id); end
    repeat (2) step();
    n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL rr_idle: got %b, expected 0", gnt_valid); end
  endtask

  task automatic test_all_grants();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    load(0, 8, 16'h0000, 1'b0);
    for (int r = 1; r < N_REQ; r++) load(r, 4, 16'(r * 16'h1000), 1'b0);
    bus.fifo_rd = 1'b1;
    drive();
    repeat (28) step();
    bus.fifo_rd = 1'b0;
    n_checks++;
    if (gnt_log.size() != 5 || burst_log.size() != 5) begin
      n_errors++;
      $display("FAIL rr_grant_count: got %0d grants/%0d bursts, expected 5/5", gnt_log.size(), burst_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (gnt_log[k] != exp_order[k]) begin n_errors++; $display("FAIL rr_order[%0d]: got %0d, expected %0d", k, gnt_log[k], exp_order[k]); end
        n_checks++;
        if (burst_log[k] != MAX_BURST) begin n_errors++; $display("FAIL rr_burst[%0d]: got %0d, expected %0d", k, burst_log[k], MAX_BURST); end
        if (k > 0) begin
          n_checks++;
          if (idle_log[k] != 1) begin n_errors++; $display("FAIL rr_gap[%0d]: got %0d, expected 1", k, idle_log[k]); end
        end
      end
    end
  endtask

  task automatic test_fill();
    int w0 = n_writes;
    int guard = 0;
    load(2, 20, 16'h2000, 1'b0);
    drive();
    while ((n_writes - w0 < 16) && (guard < 60)) begin step(); guard++; end
    n_checks++; if (guard >= 60) begin n_errors++; $display("FAIL fill_timeout: got %0d writes, expected 16", n_writes - w0); end
    repeat (4) step();
    n_checks++; if (n_writes - w0 != 16) begin n_errors++; $display("FAIL fill_writes: got %0d, expected 16", n_writes - w0); end
    n_checks++; if (level !== 5'd16) begin n_errors++; $display("FAIL fill_level: got %0d, expected 16", level); end
    n_checks++; if (gnt_valid !== 1'b1 || gnt_id !== 3'd2) begin n_errors++; $display("FAIL fill_hold: got %b/%0d, expected 1/2", gnt_valid, gnt_id); end
    n_checks++; if (bus.req_ready !== '0) begin n_errors++; $display("FAIL fill_ready: got %b, expected 0", bus.req_ready); end
    bus.fifo_rd = 1'b1;
    step();
    bus.fifo_rd = 1'b0;
    repeat (4) step();
    n_checks++; if (n_writes - w0 != 17) begin n_errors++; $display("FAIL fill_credit: got %0d writes, expected 17", n_writes - w0); end
    n_checks++; if (level !== 5'd16) begin n_errors++; $display("FAIL fill_relevel: got %0d, expected 16", level); end
    n_checks++; if (gnt_valid !== 1'b1) begin n_errors++; $display("FAIL fill_rehold: got %b, expected 1", gnt_valid); end
  endtask

  task automatic test_level_corner();
    int guard = 0;
    bus.fifo_rd = 1'b1;
    step();
    bus.fifo_rd = 1'b0;
    n_checks++; if (level !== 5'd0) begin n_errors++; $display("FAIL empty_read: got %0d, expected 0", level); end
    load(1, 6, 16'h1500, 1'b0);
    drive();
    while ((lvl_model < 5) && (guard < 30)) begin step(); guard++; end
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_errors++; $display("FAIL corner_ready: got %b, expected 0010", bus.req_ready); end
    bus.fifo_rd = 1'b1;
    step();
    bus.fifo_rd = 1'b0;
    n_checks++; if (level !== 5'd5) begin n_errors++; $display("FAIL rd_and_write: got %0d, expected 5", level); end
    repeat (2) step();
  endtask

  task automatic test_withdraw();
    int w0 = n_writes;
    load(1, 2, 16'h1100, 1'b0);
    load(2, 1, 16'h2200, 1'b1);
    drive();
    step();
    n_checks++; if (gnt_id !== 3'd1) begin n_errors++; $display("FAIL wd_grant: got %0d, expected 1", gnt_id); end
    repeat (2) step();
    n_checks++; if (gnt_valid !== 1'b1) begin n_errors++; $display("FAIL wd_held: got %b, expected 1", gnt_valid); end
    step();
    n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL wd_release: got %b, expected 0", gnt_valid); end
    n_checks++; if (n_writes - w0 != 2) begin n_errors++; $display("FAIL wd_writes: got %0d, expected 2", n_writes - w0); end
    step();
    n_checks++; if (gnt_valid !== 1'b1 || gnt_id !== 3'd2) begin n_errors++; $display("FAIL wd_next: got %b/%0d, expected 1/2", gnt_valid, gnt_id); end
    repeat (2) step();
    n_checks++; if (n_writes - w0 != 3) begin n_errors++; $display("FAIL wd_total: got %0d, expected 3", n_writes - w0); end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < N_REQ; i++) begin
      n_checks++;
      if (stat_cnt[i*16 +: 16] !== 16'(acc_cnt[i])) begin
        n_errors++;
        $display("FAIL stat_cnt[%0d]: got %0d, expected %0d", i, stat_cnt[i*16 +: 16], acc_cnt[i]);
      end
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_checks++; if (stat_cnt !== '0) begin n_errors++; $display("FAIL stat_clr: got %h, expected 0", stat_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    int guard = 0;
    load(3, 12, 16'h3000, 1'b0);
    drive();
    while ((lvl_model < 7) && (guard < 30)) begin step(); guard++; end
    n_checks++; if (bus.fifo_we !== 1'b1 || gnt_valid !== 1'b1) begin n_errors++; $display("FAIL mid_pre: got we=%b gnt=%b, expected 1/1", bus.fifo_we, gnt_valid); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.fifo_we !== 1'b0) begin n_errors++; $display("FAIL mid_we: got %b, expected 0", bus.fifo_we); end
    n_checks++; if (gnt_valid !== 1'b0) begin n_errors++; $display("FAIL mid_gnt: got %b, expected 0", gnt_valid); end
    n_checks++; if (level !== 5'd0) begin n_errors++; $display("FAIL mid_level: got %0d, expected 0", level); end
`ifdef FIFO_ARB_STATS_EN
    n_checks++; if (stat_cnt !== '0) begin n_errors++; $display("FAIL mid_stat: got %h, expected 0", stat_cnt); end
`endif
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_ptr();
    apply_reset();
    test_all_grants();
    apply_reset();
    test_fill();
    apply_reset();
    test_level_corner();
    apply_reset();
    test_withdraw();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    apply_reset();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
